// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry instruction FIFO.
// Issues word-aligned PCs to a valid/ready memory port, tags each accepted
// request with its PC in a small in-flight FIFO, and stores returned words
// with their PCs. Redirects flush the queue and drop responses still in flight.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present a response on the
// output in the same cycle it arrives when the queue is empty.
module fetch_queue #(
  parameter int unsigned  DEPTH    = 4,
  parameter logic [31:0]  RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req_valid,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_req_ready,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  output logic                       out_valid,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Credit limit compared against count + outstanding (one extra bit of headroom).
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_reg,     fetch_pc_next;
  logic [PTR_W-1:0] rd_ptr_reg,       rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg,       wr_ptr_next;
  logic [CNT_W-1:0] count_reg,        count_next;
  logic [CNT_W-1:0] outstanding_reg,  outstanding_next;
  logic [CNT_W-1:0] discard_reg,      discard_next;
  logic [PTR_W-1:0] tag_rd_ptr_reg,   tag_rd_ptr_next;
  logic [PTR_W-1:0] tag_wr_ptr_reg,   tag_wr_ptr_next;

  // Instruction queue storage (instr + pc) and the in-flight PC tag store.
  logic [31:0] fifo_instr_mem [DEPTH];
  logic [31:0] fifo_pc_mem    [DEPTH];
  logic [31:0] tag_mem        [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] credit_sum;
  logic           credit_ok;
  logic           req_fire;
  logic           rsp_fire;
  logic           rsp_drop;
  logic           rsp_keep;
  logic           tag_pop;
  logic           fifo_empty;
  logic           bypass_act;
  logic           pop_fifo;
  logic           push_fifo;
  logic [31:0]    rsp_tag;
  logic [31:0]    head_instr;
  logic [31:0]    head_pc;

  // Only registered occupancy counts toward credits, so a pop this cycle
  // frees a slot no earlier than next cycle.
  assign credit_sum = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign credit_ok  = (credit_sum < CREDIT_LIMIT);

  assign mem_req_valid = !reset && credit_ok;
  assign mem_req_addr  = fetch_pc_reg;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_fire = mem_rsp_valid && (outstanding_reg != '0);
  assign rsp_drop = rsp_fire && (discard_reg != '0);
  // Responses arriving with a redirect belong to the old stream: never kept.
  assign rsp_keep = rsp_fire && !rsp_drop && !redirect_valid;
  // Tags exist only for requests of the current stream; discarded responses
  // were cleared from the tag store when the redirect happened.
  assign tag_pop  = rsp_fire && (discard_reg == '0);
  assign rsp_tag  = tag_mem[tag_rd_ptr_reg];

  assign fifo_empty = (count_reg == '0);
  assign head_instr = fifo_instr_mem[rd_ptr_reg];
  assign head_pc    = fifo_pc_mem[rd_ptr_reg];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_act = fifo_empty && rsp_keep;
`else
  assign bypass_act = 1'b0;
`endif

  // Output view: queue head when occupied, otherwise the bypassed response.
  always_comb begin
    out_valid = 1'b0;
    out_instr = 32'h0;
    out_pc    = 32'h0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_instr = head_instr;
      out_pc    = head_pc;
    end else if (bypass_act) begin
      out_valid = 1'b1;
      out_instr = mem_rsp_data;
      out_pc    = rsp_tag;
    end
  end

  // A bypassed word taken by the consumer never enters the queue.
  assign pop_fifo  = !fifo_empty && out_ready;
  assign push_fifo = rsp_keep && !(bypass_act && out_ready);

  assign occupancy = count_reg;

  // ---------------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------------

  // Counter and pointer updates; redirect overrides everything except the
  // outstanding count, which keeps tracking the old stream's requests.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    count_next       = count_reg;
    discard_next     = discard_reg;
    tag_rd_ptr_next  = tag_rd_ptr_reg;
    tag_wr_ptr_next  = tag_wr_ptr_reg;
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    if (redirect_valid) begin
      // Every request still out after this cycle's accounting is stale.
      fetch_pc_next   = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      count_next      = '0;
      discard_next    = outstanding_next;
      tag_rd_ptr_next = '0;
      tag_wr_ptr_next = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_next   = fetch_pc_reg + 32'd4;
        tag_wr_ptr_next = tag_wr_ptr_reg + PTR_W'(1);
      end
      if (tag_pop) begin
        tag_rd_ptr_next = tag_rd_ptr_reg + PTR_W'(1);
      end
      if (rsp_drop) begin
        discard_next = discard_reg - CNT_W'(1);
      end
      if (push_fifo) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop_fifo) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Control state with asynchronous reset back to the idle, empty condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      tag_rd_ptr_reg  <= '0;
      tag_wr_ptr_reg  <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
    end
  end

  // Queue storage: contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      fifo_instr_mem[wr_ptr_reg] <= mem_rsp_data;
      fifo_pc_mem[wr_ptr_reg]    <= rsp_tag;
    end
  end

  // In-flight tag store: the PC of every accepted request, in issue order.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with an in-order,
// variable-latency memory model. Expected instructions are queued when a
// request is accepted and checked when the consumer pops the queue head.
module tb_fetch_queue;

  localparam int          DEPTH       = 4;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(TB_RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_item_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  sb_item_t    sb_q[$];
  pend_t       pend_q[$];
  int          cyc;
  int          rsp_lat;
  int          n_checks;
  int          n_fails;
  int          acc_cnt;
  int          pop_cnt;
  int          snap;
  logic [31:0] exp_addr;
  sb_item_t    sb_head;
  pend_t       pend_new;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h0010_0193;
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory response driver: oldest pending request answers once its due cycle arrives.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset || pend_q.size() == 0 || pend_q[0].due > cyc) begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
      end else begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_q[0].addr);
      end
    end
  end

  // Monitor: sample handshakes mid-cycle, update memory model and scoreboard.
  initial begin
    exp_addr = TB_RESET_PC;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        pend_q.delete();
        exp_addr = TB_RESET_PC;
      end else begin
        if (out_valid && out_ready) begin
          pop_cnt++;
          if (sb_q.size() == 0) begin
            check_eq("pop_unexpected", 32'(out_valid), 32'd0);
          end else begin
            sb_head = sb_q.pop_front();
            $display("pop  pc=%08h instr=%08h", out_pc, out_instr);
            check_eq("out_pc", out_pc, sb_head.pc);
            check_eq("out_instr", out_instr, sb_head.instr);
          end
        end
        if (mem_rsp_valid && pend_q.size() > 0) begin
          void'(pend_q.pop_front());
        end
        if (mem_req_valid && mem_req_ready) begin
          acc_cnt++;
          check_eq("req_addr", mem_req_addr, exp_addr);
          sb_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
          pend_new.addr = mem_req_addr;
          pend_new.due  = cyc + rsp_lat;
          pend_q.push_back(pend_new);
          exp_addr = exp_addr + 32'd4;
        end
        if (redirect_valid) begin
          sb_q.delete();
          exp_addr = redirect_pc & 32'hFFFF_FFFC;
        end
      end
    end
  end

  // Watchdog: the sequence is fixed-length, so this only fires on a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails = 0;
    acc_cnt = 0;
    pop_cnt = 0;
    rsp_lat = 1;
    reset = 1'b1;
    mem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Reset values.
    #3;
    check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_req_addr", mem_req_addr, TB_RESET_PC);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    step(3);

    // Streaming from reset, including the 32-bit address wrap.
    reset = 1'b0;
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("first_req_valid", 32'(mem_req_valid), 32'd1);
    check_eq("first_req_addr", mem_req_addr, TB_RESET_PC);
    step(6);
    snap = pop_cnt;
    step(10);
    check_eq("stream_rate", 32'(pop_cnt - snap), 32'd10);

    // Backpressure: exactly DEPTH accepts, then issue stalls until a pop.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    snap = acc_cnt;
    step(12);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_accepts", 32'(acc_cnt - snap), 32'd4);
    check_eq("bp_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("bp_occupancy", 32'(occupancy), 32'd4);
    check_eq("bp_head_pc", out_pc, 32'h0000_0200);
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_resume", 32'(mem_req_valid), 32'd1);
    step();
    out_ready = 1'b1;
    step(8);

    // Redirect with two requests outstanding: both responses dropped.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0010;
    mem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(8);
    rsp_lat = 5;
    mem_req_ready = 1'b1;
    snap = acc_cnt;
    step(2);
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check_eq("two_outstanding", 32'(acc_cnt - snap), 32'd2);
    step();
    redirect_valid = 1'b0;
    rsp_lat = 1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("redir_req_addr", mem_req_addr, 32'h0000_0100);
    check_eq("redir_req_valid", 32'(mem_req_valid), 32'd1);
    check_eq("redir_out_valid", 32'(out_valid), 32'd0);
    step(12);

    // Redirect in the same cycle as a response and a pop.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_001C;
    mem_req_ready = 1'b0;
    out_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    step(8);
    mem_req_ready = 1'b1;
    step(2);
    mem_req_ready = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    check_eq("rdr_rsp_present", 32'(mem_rsp_valid), 32'd1);
    check_eq("rdr_occ_before", 32'(occupancy), 32'd1);
    step();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check_eq("rdr_occ_after", 32'(occupancy), 32'd0);
    check_eq("rdr_out_valid", 32'(out_valid), 32'd0);
    step(6);

    // Single response into an empty queue with the consumer ready.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    mem_req_ready = 1'b0;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    step(8);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    check_eq("bp1_rsp_present", 32'(mem_rsp_valid), 32'd1);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("byp_out_valid", 32'(out_valid), 32'd1);
    check_eq("byp_out_instr", out_instr, 32'h0010_0193);
    check_eq("byp_out_pc", out_pc, 32'h0000_0040);
    check_eq("byp_occupancy", 32'(occupancy), 32'd0);
`else
    check_eq("nobyp_out_valid", 32'(out_valid), 32'd0);
    check_eq("nobyp_occupancy", 32'(occupancy), 32'd0);
`endif
    step();
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    check_eq("byp_occ_next", 32'(occupancy), 32'd0);
    check_eq("byp_valid_next", 32'(out_valid), 32'd0);
`else
    check_eq("nobyp_occ_next", 32'(occupancy), 32'd1);
    check_eq("nobyp_valid_next", 32'(out_valid), 32'd1);
    check_eq("nobyp_instr_next", out_instr, 32'h0010_0193);
`endif
    step(3);

    // Reset in the middle of streaming.
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    step(6);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("mid_rst_req_addr", mem_req_addr, TB_RESET_PC);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_occupancy", 32'(occupancy), 32'd0);
    step(2);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    check_eq("post_rst_req_addr", mem_req_addr, TB_RESET_PC);
    step(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly upstream of the single-cycle decode/execute datapath. Generates sequential word-aligned PCs, issues them to a valid/ready instruction memory port with in-order, variable-latency responses, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Branch/jump redirects flush the queue and discard responses still in flight.

## Interface

- DEPTH, 4, FIFO entries; power of two, 2..16; also the limit on outstanding requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  fetch address, always word-aligned
- mem_req_ready  in  1  memory accepts request this cycle
- mem_rsp_valid  in  1  response valid; in request order, at least 1 cycle after acceptance
- mem_rsp_data  in  32  instruction word
- out_valid  out  1  queue head valid
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_ready  in  1  consumer takes head this cycle
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 0
- occupancy  out  $clog2(DEPTH)+1  valid entries in FIFO

## Operation

- Registers: fetch_pc, FIFO storage (instr+pc), rd/wr pointers, count, outstanding, discard, and a pc FIFO (DEPTH) tagging in-flight requests.
- Issue: mem_req_valid = !reset && (count + outstanding < DEPTH) (registered values; a same-cycle pop does not add a credit). mem_req_addr = fetch_pc.
- Accept (valid && ready): fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); outstanding += 1; pc pushed to tag FIFO.
- Response: outstanding -= 1; tag popped. If discard > 0, discard -= 1 and data dropped; else {data, tag} written to FIFO tail.
- Pop: out_valid && out_ready removes head.
- Redirect (highest priority): FIFO emptied (count 0, pointers reset); fetch_pc = {redirect_pc[31:2], 2'b00}; discard = outstanding after this cycle's accept/response accounting; tag FIFO emptied. Any same-cycle pop, accept and response belong to the old stream; accepted request counted in discard, response dropped.
- Unaccepted request under redirect is retracted: mem_req_addr may change the next cycle without acceptance. Memory must tolerate this.
- Simultaneous push and pop at count == DEPTH cannot occur (credit rule); push and pop same cycle leaves count unchanged.
- Response with outstanding == 0: protocol violation; ignored.

## Timing

- Reset values: mem_req_valid 0, mem_req_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, occupancy 0; all counters 0.
- First cycle after reset deassertion: mem_req_valid 1, addr RESET_PC.
- Throughput: one request per cycle while credits available; one instruction per cycle out.
- Response to out_valid: 1 cycle (registered FIFO) unless bypass enabled.
- Cycle after redirect: out_valid 0, mem_req_addr = redirect target if credits allow (count 0, outstanding includes discards).
- Reset mid-operation: immediate return to reset values; pending responses after reset are not tracked by the block (memory is reset together).

## Configuration

- FETCH_QUEUE_BYPASS_EN defined: when FIFO empty and a non-discarded response arrives, out_valid/out_instr/out_pc reflect it combinationally the same cycle; if out_ready also high, it is consumed and not written. Redirect same cycle suppresses bypass.
- Undefined: responses always written to FIFO; out_valid earliest the following cycle; out_* purely registered.

## Test plan

- Reset, mem_req_ready=1, response 1 cycle later, out_ready=1 -> out_pc 0x0,0x4,0x8,... one per cycle, instructions in order.
- out_ready=0, DEPTH=4, memory always ready -> exactly 4 accepts, then mem_req_valid 0, occupancy 4; out_ready=1 resumes issue next cycle.
- 2 requests outstanding (0x10, 0x14), redirect_pc 0x103 -> both responses dropped, next request addr 0x100, first out_pc 0x100.
- Redirect same cycle as response for 0x20 and pop -> response dropped, occupancy 0 next cycle, out_valid 0.
- RESET_PC 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Bypass on, empty queue, response 0x00100193 with out_ready=1 -> out_valid and out_instr same cycle, occupancy stays 0; bypass off -> out_valid one cycle later.
